// File: rtl/mux_arbiter_4x2_pkg.sv
// Shared types and constants for the two-lane, four-FIFO round-robin mux arbiter.
// Holds the FSM state encoding, the lane indices and the per-pair grant function.
package mux_arbiter_4x2_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;

    localparam int NUM_LANES = 2;
    localparam int LANE_00   = 0;
    localparam int LANE_11   = 1;
    localparam int CNT_W     = 8;

    // Grant for one FIFO pair: a lone requester wins outright, a tie goes to the rr pointer.
    function automatic logic [1:0] rr_grant(input logic rr, input logic [1:0] empty);
        logic [1:0] grant;
        grant = 2'b00;
        case (~empty)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/mux_arbiter_4x2_rr_pair.sv
// Round-robin arbiter for one pair of show-ahead FIFOs feeding a single output lane.
// Issues at most one combinational pop per cycle and flips its pointer after every pop.
module rr_pair_arbiter
    import mux_arbiter_4x2_pkg::*;
(
    input  logic       clk_f,
    input  logic       reset,
    input  logic       arb_en,
    input  logic [1:0] empty,
    output logic [1:0] pop,
    output logic       sel
);

    logic rr_q;

    always_comb begin
        pop = 2'b00;
        if (arb_en && !reset) begin
            pop = rr_grant(rr_q, empty);
        end
    end

    assign sel = pop[1];

    // After popping the lower FIFO the pointer moves to the upper one, and vice versa.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (|pop) begin
            rr_q <= pop[0];
        end
    end

endmodule

// File: rtl/mux_arbiter_4x2.sv
// Four input FIFOs merged onto two registered output lanes: FIFOs 0/1 feed lane 00,
// FIFOs 2/3 feed lane 11, each pair arbitrated independently in round-robin order.
module mux_arbiter_4x2
    import mux_arbiter_4x2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic [DATA_W-1:0] fifo_data_2,
    input  logic [DATA_W-1:0] fifo_data_3,
    input  logic [1:0]        out_afull,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_00,
    output logic [DATA_W-1:0] data_11,
    output logic              valid_00,
    output logic              valid_11,
    output logic [CNT_W-1:0]  cnt_00,
    output logic [CNT_W-1:0]  cnt_11,
    output logic              idle
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic                 arb_permit;
    logic [1:0]           pair_en;
    logic [1:0]           pop_a;
    logic [1:0]           pop_b;
    logic                 sel_a;
    logic                 sel_b;
    logic [NUM_LANES-1:0] lane_pop;
    logic [DATA_W-1:0]    lane_word  [NUM_LANES];
    logic [DATA_W-1:0]    lane_data  [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic [CNT_W-1:0]     lane_cnt   [NUM_LANES];
    logic                 idle_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with the live enable makes a falling enable suppress pops in that very cycle.
    assign arb_permit = (state_q == ACTIVE) && enable && !reset;
    assign pair_en[LANE_00] = arb_permit && !out_afull[LANE_00];
    assign pair_en[LANE_11] = arb_permit && !out_afull[LANE_11];

    rr_pair_arbiter u_pair_a (
        .clk_f  (clk_f),
        .reset  (reset),
        .arb_en (pair_en[LANE_00]),
        .empty  (fifo_empty[1:0]),
        .pop    (pop_a),
        .sel    (sel_a)
    );

    rr_pair_arbiter u_pair_b (
        .clk_f  (clk_f),
        .reset  (reset),
        .arb_en (pair_en[LANE_11]),
        .empty  (fifo_empty[3:2]),
        .pop    (pop_b),
        .sel    (sel_b)
    );

    assign pop = {pop_b, pop_a};

    assign lane_pop[LANE_00]  = |pop_a;
    assign lane_pop[LANE_11]  = |pop_b;
    assign lane_word[LANE_00] = sel_a ? fifo_data_1 : fifo_data_0;
    assign lane_word[LANE_11] = sel_b ? fifo_data_3 : fifo_data_2;

    // Output registers: data holds when the lane does not pop, valid is a one-cycle strobe.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q <= IDLE;
            idle_q  <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_data[k]  <= '0;
                lane_valid[k] <= 1'b0;
                lane_cnt[k]   <= '0;
            end
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d == IDLE) && (&fifo_empty);
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_valid[k] <= lane_pop[k];
                if (lane_pop[k]) begin
                    lane_data[k] <= lane_word[k];
                    lane_cnt[k]  <= lane_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign data_00  = lane_data[LANE_00];
    assign data_11  = lane_data[LANE_11];
    assign valid_00 = lane_valid[LANE_00];
    assign valid_11 = lane_valid[LANE_11];
    assign cnt_00   = lane_cnt[LANE_00];
    assign cnt_11   = lane_cnt[LANE_11];
    assign idle     = idle_q;

endmodule

// File: tb/tb_mux_arbiter_4x2.sv
// Self-checking bench for mux_arbiter_4x2: emulated show-ahead FIFOs plus a queue-level
// reference model of the two round-robin lanes, with directed and randomized scenarios.
module tb_mux_arbiter_4x2;

    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk_f = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    fifo_empty = 4'hF;
    logic [DW-1:0] fifo_data_0 = '0;
    logic [DW-1:0] fifo_data_1 = '0;
    logic [DW-1:0] fifo_data_2 = '0;
    logic [DW-1:0] fifo_data_3 = '0;
    logic [1:0]    out_afull = 2'b00;
    logic [3:0]    pop;
    logic [DW-1:0] data_00;
    logic [DW-1:0] data_11;
    logic          valid_00;
    logic          valid_11;
    logic [7:0]    cnt_00;
    logic [7:0]    cnt_11;
    logic          idle;

    mux_arbiter_4x2 #(.DATA_W(DW)) dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data_0 (fifo_data_0),
        .fifo_data_1 (fifo_data_1),
        .fifo_data_2 (fifo_data_2),
        .fifo_data_3 (fifo_data_3),
        .out_afull   (out_afull),
        .pop         (pop),
        .data_00     (data_00),
        .data_11     (data_11),
        .valid_00    (valid_00),
        .valid_11    (valid_11),
        .cnt_00      (cnt_00),
        .cnt_11      (cnt_11),
        .idle        (idle)
    );

    always #5 clk_f = ~clk_f;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [4][DEPTH];
    int            rd  [4];
    int            wr  [4];
    int            ch  [2];
    bit            m_active;
    bit            m_rr    [2];
    logic [DW-1:0] m_data  [2];
    bit            m_valid [2];
    int            m_cnt   [2];
    bit            m_idle;
    logic [3:0]    exp_pop;
    logic [3:0]    pop_seen;
    logic [34:0]   exp_out;
    wire  [34:0]   obs_out = {valid_00, data_00, cnt_00, valid_11, data_11, cnt_11, idle};

    task automatic push(input int f, input logic [DW-1:0] w);
        if (wr[f] < DEPTH) begin
            mem[f][wr[f]] = w;
            wr[f]++;
        end
    endtask

    task automatic flush_fifos();
        for (int i = 0; i < 4; i++) rd[i] = wr[i];
    endtask

    task automatic drive_fifos();
        logic [DW-1:0] h [4];
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (rd[i] == wr[i]);
            h[i] = fifo_empty[i] ? DW'($urandom) : mem[i][rd[i]];
        end
        fifo_data_0 = h[0];
        fifo_data_1 = h[1];
        fifo_data_2 = h[2];
        fifo_data_3 = h[3];
    endtask

    // One clock: predict the pops from the queues, sample pop mid-cycle, then retire the words.
    task automatic tick();
        bit permit;
        bit all_empty;
        bit h0;
        bit h1;
        int lo;
        drive_fifos();
        permit    = !reset && m_active && enable;
        all_empty = 1'b1;
        exp_pop   = 4'b0000;
        for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) all_empty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lo    = 2 * k;
            h0    = (rd[lo] != wr[lo]);
            h1    = (rd[lo + 1] != wr[lo + 1]);
            ch[k] = -1;
            if (permit && !out_afull[k] && (h0 || h1)) begin
                if (h0 && h1) ch[k] = lo + int'(m_rr[k]);
                else          ch[k] = h0 ? lo : lo + 1;
                exp_pop[ch[k]] = 1'b1;
            end
        end
        @(negedge clk_f);
        pop_seen = pop;
        @(posedge clk_f);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_rr[k] = 1'b0; m_data[k] = '0; m_valid[k] = 1'b0; m_cnt[k] = 0;
            end else if (ch[k] >= 0) begin
                m_data[k]  = mem[ch[k]][rd[ch[k]]];
                rd[ch[k]]  = rd[ch[k]] + 1;
                m_valid[k] = 1'b1;
                m_cnt[k]   = (m_cnt[k] + 1) % 256;
                m_rr[k]    = (ch[k] == 2 * k);
            end else begin
                m_valid[k] = 1'b0;
            end
        end
        m_idle   = !reset && !enable && all_empty;
        m_active = !reset && enable;
        exp_out  = {m_valid[0], m_data[0], 8'(m_cnt[0]), m_valid[1], m_data[1], 8'(m_cnt[1]), m_idle};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; out_afull = 2'b00;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (pop_seen !== 4'b0000) begin
                failures++; $display("[TB] FAIL reset_pop cyc=%0d got=%b want=0000", c, pop_seen);
            end
            checks++;
            if (obs_out !== 35'h0) begin
                failures++; $display("[TB] FAIL reset_outputs cyc=%0d got=%h want=0", c, obs_out);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (idle !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_idle_flag got=%b want=1", idle);
        end
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({pop_seen, valid_00, valid_11, idle} !== 7'b0) begin
                failures++;
                $display("[TB] FAIL empty_active cyc=%0d got pop=%b v00=%b v11=%b idle=%b want all 0",
                         c, pop_seen, valid_00, valid_11, idle);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL empty_active_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
        end
    endtask

    task automatic test_pair_a_sequence();
        logic [DW-1:0] want [4];
        logic [DW-1:0] seen [8];
        int n;
        want[0] = 8'h11; want[1] = 8'h21; want[2] = 8'h12; want[3] = 8'h22;
        n = 0;
        flush_fifos();
        reset = 1'b1; enable = 1'b0; out_afull = 2'b00;
        tick();
        push(0, 8'h11); push(0, 8'h12); push(1, 8'h21); push(1, 8'h22);
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (pop_seen !== exp_pop) begin
                failures++; $display("[TB] FAIL seq_pop cyc=%0d got=%b want=%b", c, pop_seen, exp_pop);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL seq_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
            if (valid_00 === 1'b1 && n < 8) begin
                seen[n] = data_00; n++;
            end
        end
        checks++;
        if (n != 4) begin
            failures++; $display("[TB] FAIL seq_count got=%0d want=4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    failures++; $display("[TB] FAIL seq_word%0d got=%h want=%h", i, seen[i], want[i]);
                end
            end
        end
        checks++;
        if (cnt_00 !== 8'd4) begin
            failures++; $display("[TB] FAIL seq_cnt00 got=%0d want=4", cnt_00);
        end
    endtask

    task automatic test_single_fifo();
        logic [DW-1:0] seen [8];
        int n;
        int pops2;
        n = 0; pops2 = 0;
        flush_fifos();
        reset = 1'b1; enable = 1'b0; out_afull = 2'b00;
        tick();
        push(2, 8'hA0); push(2, 8'hA1); push(2, 8'hA2);
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (pop_seen[2] === 1'b1) pops2++;
            checks++;
            if (pop_seen[3] !== 1'b0) begin
                failures++; $display("[TB] FAIL single_pop3 cyc=%0d got=%b want=0", c, pop_seen[3]);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL single_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
            if (valid_11 === 1'b1 && n < 8) begin
                seen[n] = data_11; n++;
            end
        end
        checks++;
        if (pops2 != 3 || n != 3) begin
            failures++; $display("[TB] FAIL single_count got pops=%0d words=%0d want 3/3", pops2, n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== 8'(8'hA0 + i)) begin
                    failures++; $display("[TB] FAIL single_word%0d got=%h want=%h", i, seen[i], 8'(8'hA0 + i));
                end
            end
        end
    endtask

    task automatic test_afull();
        logic [1:0] sched [10];
        for (int i = 0; i < 10; i++) sched[i] = (i >= 4 && i <= 6) ? 2'b10 : 2'b00;
        flush_fifos();
        for (int i = 0; i < 12; i++) begin
            for (int f = 0; f < 4; f++) push(f, DW'($urandom));
        end
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            out_afull = sched[c];
            tick();
            checks++;
            if (pop_seen !== exp_pop) begin
                failures++; $display("[TB] FAIL afull_pop cyc=%0d got=%b want=%b", c, pop_seen, exp_pop);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL afull_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
            checks++;
            if (valid_00 !== 1'b1) begin
                failures++; $display("[TB] FAIL afull_lane00 cyc=%0d got=%b want=1", c, valid_00);
            end
            checks++;
            if (valid_11 !== ((c >= 4 && c <= 6) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("[TB] FAIL afull_lane11 cyc=%0d got=%b want=%b", c, valid_11, (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
            end
        end
        out_afull = 2'b00;
    endtask

    task automatic test_cnt_wrap_and_reset();
        int lane_pops;
        lane_pops = 0;
        flush_fifos();
        reset = 1'b1; enable = 1'b0; out_afull = 2'b00;
        tick();
        for (int i = 0; i < 128; i++) begin
            push(0, DW'($urandom)); push(1, DW'($urandom));
        end
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 258; c++) begin
            tick();
            if (pop_seen[1:0] !== 2'b00) lane_pops++;
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL wrap_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
        end
        checks++;
        if (lane_pops != 256 || cnt_00 !== 8'd0) begin
            failures++; $display("[TB] FAIL wrap_cnt00 got pops=%0d cnt=%0d want 256/0", lane_pops, cnt_00);
        end
        for (int i = 0; i < 6; i++) begin
            for (int f = 0; f < 4; f++) push(f, DW'($urandom));
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (pop_seen !== 4'b0000) begin
            failures++; $display("[TB] FAIL midreset_pop got=%b want=0000", pop_seen);
        end
        checks++;
        if (obs_out !== 35'h0) begin
            failures++; $display("[TB] FAIL midreset_outputs got=%h want=0", obs_out);
        end
        reset = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            checks++;
            if (pop_seen !== exp_pop || obs_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL postreset cyc=%0d got pop=%b out=%h want pop=%b out=%h",
                         c, pop_seen, obs_out, exp_pop, exp_out);
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic [1:0] first_pop;
        bit got_first;
        got_first = 1'b0; first_pop = 2'b00;
        flush_fifos();
        for (int i = 0; i < 4; i++) begin
            push(0, DW'($urandom)); push(1, DW'($urandom));
        end
        reset = 1'b0; enable = 1'b1; out_afull = 2'b00;
        for (int c = 0; c < 3; c++) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (pop_seen !== 4'b0000) begin
            failures++; $display("[TB] FAIL disable_pop got=%b want=0000", pop_seen);
        end
        tick();
        checks++;
        if (valid_00 !== 1'b0 || obs_out !== exp_out) begin
            failures++; $display("[TB] FAIL disable_valid got v00=%b out=%h want v00=0 out=%h", valid_00, obs_out, exp_out);
        end
        enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!got_first && pop_seen[1:0] !== 2'b00) begin
                first_pop = pop_seen[1:0]; got_first = 1'b1;
            end
            checks++;
            if (pop_seen !== exp_pop || obs_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL reenable cyc=%0d got pop=%b out=%h want pop=%b out=%h",
                         c, pop_seen, obs_out, exp_pop, exp_out);
            end
        end
        checks++;
        if (first_pop !== 2'b10) begin
            failures++; $display("[TB] FAIL reenable_rr got=%b want=10", first_pop);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            for (int f = 0; f < 4; f++) begin
                if ($urandom_range(0, 2) == 0) push(f, DW'($urandom));
            end
            out_afull = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            enable    = ($urandom_range(0, 9) != 0);
            reset     = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (pop_seen !== exp_pop) begin
                failures++; $display("[TB] FAIL rand_pop cyc=%0d got=%b want=%b", c, pop_seen, exp_pop);
            end
            checks++;
            if (obs_out !== exp_out) begin
                failures++; $display("[TB] FAIL rand_model cyc=%0d got=%h want=%h", c, obs_out, exp_out);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0; wr[i] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            m_rr[k] = 1'b0; m_data[k] = '0; m_valid[k] = 1'b0; m_cnt[k] = 0; ch[k] = -1;
        end
        m_active = 1'b0; m_idle = 1'b0;
        test_reset();
        test_pair_a_sequence();
        test_single_fifo();
        test_afull();
        test_cnt_wrap_and_reset();
        test_enable_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
